// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub datapath stages.
package fp_pkg;

  localparam int FP_EXP_WIDTH = 8;
  localparam int FP_MAN_WIDTH = 23;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero;
  } fp_flags_t;

endpackage

// File: rtl/fp_norm_exp_update.sv
// Post-add normalization: right shift on carry-out or iterative 1-bit left
// shifts until the hidden bit is set, with exponent update and status flags.
module fp_norm_exp_update
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH = FP_EXP_WIDTH,
  parameter int MAN_WIDTH = FP_MAN_WIDTH,
  localparam int SUM_W = MAN_WIDTH + 5,
  localparam int SHW = $clog2(SUM_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [SUM_W-1:0]     in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic [MAN_WIDTH-1:0] out_man,
  output logic [2:0]           out_grs,
  output logic [SHW-1:0]       shift_spaces,
  output logic                 shift_dir,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 zero
);

  norm_state_t          r_state;
  logic                 r_in_ready;
  logic                 r_sign;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [SUM_W-1:0]     r_sum;
  logic [SHW-1:0]       r_cnt;

  logic                 r_out_valid;
  logic                 r_out_sign;
  logic [EXP_WIDTH-1:0] r_out_exp;
  logic [MAN_WIDTH-1:0] r_out_man;
  logic [2:0]           r_out_grs;
  logic [SHW-1:0]       r_out_cnt;
  logic                 r_out_dir;
  fp_flags_t            r_out_flags;

  logic                 w_done;
  logic [EXP_WIDTH-1:0] w_res_exp;
  logic [MAN_WIDTH-1:0] w_res_man;
  logic [2:0]           w_res_grs;
  logic [SHW-1:0]       w_res_cnt;
  logic                 w_res_dir;
  fp_flags_t            w_res_flags;
  logic [EXP_WIDTH-1:0] w_exp_inc;

  assign w_exp_inc = r_exp + EXP_WIDTH'(1);

  // One NORM step: decide whether this cycle finishes and what it produces.
  always_comb begin
    w_done      = 1'b0;
    w_res_exp   = r_exp;
    w_res_man   = r_sum[SUM_W-3:3];
    w_res_grs   = r_sum[2:0];
    w_res_cnt   = r_cnt;
    w_res_dir   = 1'b0;
    w_res_flags = '0;
    if (r_sum == '0) begin
      w_done           = 1'b1;
      w_res_exp        = '0;
      w_res_flags.zero = 1'b1;
    end else if (r_sum[SUM_W-1]) begin
      // Right shift by one folded into the slice; shifted-out bit joins sticky.
      w_done    = 1'b1;
      w_res_dir = 1'b1;
      w_res_cnt = SHW'(1);
      w_res_exp = w_exp_inc;
      if (w_exp_inc == '1) begin
        w_res_flags.overflow = 1'b1;
        w_res_man            = '0;
        w_res_grs            = '0;
      end else begin
        w_res_man = r_sum[SUM_W-2:4];
        w_res_grs = {r_sum[3], r_sum[2], r_sum[1] | r_sum[0]};
      end
    end else if (r_sum[SUM_W-2]) begin
      w_done = 1'b1;
      if (r_exp == '0) w_res_exp = EXP_WIDTH'(1);
    end else if (r_exp <= EXP_WIDTH'(1)) begin
      w_done                = 1'b1;
      w_res_exp             = '0;
      w_res_flags.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_man   <= '0;
      r_out_grs   <= '0;
      r_out_cnt   <= '0;
      r_out_dir   <= 1'b0;
      r_out_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_sign     <= in_sign;
            r_exp      <= in_exp;
            r_sum      <= in_sum;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= NORM;
          end
        end
        NORM: begin
          if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_sign  <= r_sign;
            r_out_exp   <= w_res_exp;
            r_out_man   <= w_res_man;
            r_out_grs   <= w_res_grs;
            r_out_cnt   <= w_res_cnt;
            r_out_dir   <= w_res_dir;
            r_out_flags <= w_res_flags;
            r_state     <= DONE;
          end else begin
            r_sum <= {r_sum[SUM_W-2:0], 1'b0};
            r_exp <= r_exp - EXP_WIDTH'(1);
            r_cnt <= r_cnt + SHW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sign     = r_out_sign;
  assign out_exp      = r_out_exp;
  assign out_man      = r_out_man;
  assign out_grs      = r_out_grs;
  assign shift_spaces = r_out_cnt;
  assign shift_dir    = r_out_dir;
  assign overflow     = r_out_flags.overflow;
  assign underflow    = r_out_flags.underflow;
  assign zero         = r_out_flags.zero;

endmodule
